key_debounce: RTL and testbench

Multi-channel push-button input conditioner, the input-side counterpart to the LED output drivers. It synchronises raw board key inputs to `sys_clk` and filters contact bounce with a per-key hold-time counter. Each key produces a stable debounced level plus single-cycle press and release strobes. Downstream control logic, such as LED pattern selectors and mode switches, consumes the strobes directly.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_filter.sv | 94 +++++++++
 rtl/key_debounce.sv | 35 +++
 tb/tb_key_debounce.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: filter FSM encoding, default hold time
// and the counter-width helper.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    P_FILT = 2'd1,
    DOWN   = 2'd2,
    R_FILT = 2'd3
  } filt_state_e;

  localparam int CNT_MAX_20MS = 1_000_000;

  // Never returns zero, so a CNT_MAX of 1 still yields a legal 1-bit counter.
  function automatic int cnt_width(input int cnt_max);
    return (cnt_max > 1) ? $clog2(cnt_max) : 1;
  endfunction

endpackage

// File: rtl/key_filter.sv
// Single key channel: 2-flop synchroniser, press/release hold-time FSM and
// registered level/strobe outputs.
module key_filter
  import key_pkg::*;
#(
  parameter int   CNT_MAX    = CNT_MAX_20MS,
  parameter logic KEY_ACTIVE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_state,
  output logic o_press,
  output logic o_release
);

  localparam int            CW       = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [1:0]    r_sync;
  filt_state_e   r_fsm;
  logic [CW-1:0] r_cnt;
  logic          r_state;
  logic          r_press;
  logic          r_release;
  logic          w_act;

  assign w_act = (r_sync[1] == KEY_ACTIVE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // Synchroniser parks at the released level so a held key is re-qualified.
      r_sync    <= {2{~KEY_ACTIVE}};
      r_fsm     <= IDLE;
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (w_act) begin
            r_fsm <= P_FILT;
            r_cnt <= '0;
          end
        end
        P_FILT: begin
          if (!w_act) begin
            r_fsm <= IDLE;
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_fsm   <= DOWN;
            r_cnt   <= '0;
            r_press <= 1'b1;
            r_state <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DOWN: begin
          if (!w_act) begin
            r_fsm <= R_FILT;
            r_cnt <= '0;
          end
        end
        R_FILT: begin
          if (w_act) begin
            r_fsm <= DOWN;
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_fsm     <= IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_state   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_fsm <= IDLE;
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: one independent key_filter per key pin,
// sharing only clock and reset.
module key_debounce
  import key_pkg::*;
#(
  parameter int   KEY_NUM    = 4,
  parameter int   CNT_MAX    = CNT_MAX_20MS,
  parameter logic KEY_ACTIVE = 1'b0
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release
);

  genvar gi;
  generate
    for (gi = 0; gi < KEY_NUM; gi++) begin : g_key
      key_filter #(
        .CNT_MAX   (CNT_MAX),
        .KEY_ACTIVE(KEY_ACTIVE)
      ) u_filter (
        .i_clk    (sys_clk),
        .i_rst_n  (sys_rst_n),
        .i_key    (key_in[gi]),
        .o_state  (key_state[gi]),
        .o_press  (key_press[gi]),
        .o_release(key_release[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=8: reset, clean press/release,
// bounce, simultaneous keys, reset mid-filter and release glitch.
module tb_key_debounce;

  localparam int KN  = 4;
  localparam int CM  = 8;
  localparam int LAT = CM + 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [KN-1:0] key_in;
  logic [KN-1:0] key_state;
  logic [KN-1:0] key_press;
  logic [KN-1:0] key_release;

  int n_tests = 0;
  int n_fail  = 0;
  int press_cnt [KN];
  int rel_cnt   [KN];
  int base_p, base_r;

  key_debounce #(
    .KEY_NUM   (KN),
    .CNT_MAX   (CM),
    .KEY_ACTIVE(1'b0)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 sys_clk = ~sys_clk;

  // Strobe counters sampled mid-cycle, used for "no strobe" windows.
  always @(negedge sys_clk) begin
    for (int i = 0; i < KN; i++) begin
      if (key_press[i] === 1'b1)   press_cnt[i]++;
      if (key_release[i] === 1'b1) rel_cnt[i]++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Inputs were just changed; the strobe must appear after exactly LAT edges.
  task automatic expect_strobe(input string tag, input bit rel, input logic [KN-1:0] mask);
    tick(LAT - 1);
    check_eq({tag, "_early"}, rel ? key_release : key_press, 0);
    tick(1);
    check_eq({tag, "_pulse"}, rel ? key_release : key_press, mask);
    check_eq({tag, "_excl"},  rel ? key_press : key_release, 0);
    tick(1);
    check_eq({tag, "_width"}, rel ? key_release : key_press, 0);
    check_eq({tag, "_state"}, key_state & mask, rel ? 0 : mask);
    $display("[TB] %s: %s strobe mask %b", tag, rel ? "release" : "press", mask);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_in    = 4'b0000;

    // 1. Reset with all keys held
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("rst_outs", {key_state, key_press, key_release}, 0);
    end
    sys_rst_n = 1'b1;
    expect_strobe("rst_hold", 1'b0, 4'b1111);
    key_in = 4'b1111;
    expect_strobe("rst_rel_all", 1'b1, 4'b1111);

    // 2. Clean press and release on key 0
    for (int i = 1; i < KN; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
    key_in[0] = 1'b0;
    expect_strobe("clean_press", 1'b0, 4'b0001);
    tick(8);
    check_eq("clean_hold_state", key_state, 4'b0001);
    key_in[0] = 1'b1;
    expect_strobe("clean_rel", 1'b1, 4'b0001);
    check_eq("clean_others_quiet", press_cnt[1] + press_cnt[2] + press_cnt[3]
             + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);

    // 3. Bounce rejection on key 1
    base_p = press_cnt[1];
    key_in[1] = 1'b0; tick(1);
    key_in[1] = 1'b1; tick(2);
    key_in[1] = 1'b0; tick(3);
    key_in[1] = 1'b1; tick(2);
    key_in[1] = 1'b0; tick(7);
    key_in[1] = 1'b1; tick(2);
    check_eq("bounce_no_strobe", press_cnt[1] - base_p, 0);
    check_eq("bounce_state", key_state[1], 1'b0);
    key_in[1] = 1'b0;
    expect_strobe("bounce_final", 1'b0, 4'b0010);
    check_eq("bounce_single", press_cnt[1] - base_p, 1);
    key_in[1] = 1'b1;
    expect_strobe("bounce_rel", 1'b1, 4'b0010);

    // 4. Simultaneous keys 2 and 3
    key_in[3:2] = 2'b00;
    expect_strobe("simul_press", 1'b0, 4'b1100);
    key_in[3:2] = 2'b11;
    expect_strobe("simul_rel", 1'b1, 4'b1100);

    // 5. Reset while key 0 is mid-filter (cnt=5 after 8 edges)
    base_p = press_cnt[0];
    key_in[0] = 1'b0;
    tick(8);
    sys_rst_n = 1'b0;
    tick(3);
    check_eq("midrst_outs", {key_state, key_press, key_release}, 0);
    check_eq("midrst_no_strobe", press_cnt[0] - base_p, 0);
    sys_rst_n = 1'b1;
    expect_strobe("midrst_requal", 1'b0, 4'b0001);

    // 6. Release glitch while DOWN
    base_r = rel_cnt[0];
    key_in[0] = 1'b1; tick(4);
    key_in[0] = 1'b0; tick(20);
    check_eq("glitch_no_release", rel_cnt[0] - base_r, 0);
    check_eq("glitch_state", key_state[0], 1'b1);
    key_in[0] = 1'b1;
    expect_strobe("glitch_final_rel", 1'b1, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
